// File: rtl/div_pkg.sv
// Shared types and packing helpers for the sequential restoring divider.
// Result layout on dataOut is {remainder (HI), quotient (LO)}.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int QUOT_LSB = 0;

  // The remainder sits directly above the quotient, so its offset is the operand width.
  function automatic int rem_lsb(input int width);
    return width;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_bit,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_shift = {i_rem, i_bit};
  assign w_ge    = w_shift >= {2'b00, i_divisor};
  // Only taken when w_ge holds, so the true difference always fits in WIDTH+1 bits.
  assign w_diff  = w_shift[WIDTH:0] - {1'b0, i_divisor};
  assign o_rem   = w_ge ? w_diff : w_shift[WIDTH:0];
  assign o_qbit  = w_ge;

endmodule

// File: rtl/divider_seq_param.sv
// Multi-cycle restoring divider (DIV/DIVU) with start/busy/done handshake.
// Fixed latency: WIDTH restoring steps, one sign-fixup cycle, one done cycle.
module divider_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   dataOut
);

  localparam int CW      = $clog2(WIDTH + 1);
  localparam int REM_LSB = rem_lsb(WIDTH);

  state_t             r_state, w_next;
  logic [CW-1:0]      r_count;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_sign_q, r_sign_r, r_b_zero;
  logic [2*WIDTH-1:0] r_data_out;
  logic               r_dbz;

  logic               w_sa, w_sb;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_step_rem;
  logic               w_step_q;
  logic [WIDTH-1:0]   w_rem_lo, w_q_fix, w_r_fix;

  // Negating MIN yields MIN, which read as unsigned is exactly 2^(WIDTH-1).
  assign w_sa    = is_signed & dataA[WIDTH-1];
  assign w_sb    = is_signed & dataB[WIDTH-1];
  assign w_mag_a = w_sa ? -dataA : dataA;
  assign w_mag_b = w_sb ? -dataB : dataB;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_divisor (r_divisor),
    .i_bit     (r_quot[WIDTH-1]),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_q)
  );

  // Divide-by-zero keeps the all-ones quotient; re-signing the remainder magnitude restores dataA.
  assign w_rem_lo = r_rem[WIDTH-1:0];
  assign w_q_fix  = (r_sign_q && !r_b_zero) ? -r_quot : r_quot;
  assign w_r_fix  = r_sign_r ? -w_rem_lo : w_rem_lo;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (r_count == CW'(WIDTH - 1)) w_next = FIXUP;
      FIXUP:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_divisor  <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_b_zero   <= 1'b0;
      r_data_out <= '0;
      r_dbz      <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: if (start) begin
          r_count   <= '0;
          r_rem     <= '0;
          r_quot    <= w_mag_a;
          r_divisor <= w_mag_b;
          r_sign_q  <= w_sa ^ w_sb;
          r_sign_r  <= w_sa;
          r_b_zero  <= (dataB == '0);
        end
        CALC: begin
          r_rem   <= w_step_rem;
          r_quot  <= {r_quot[WIDTH-2:0], w_step_q};
          r_count <= r_count + 1'b1;
        end
        FIXUP: begin
          r_data_out[QUOT_LSB +: WIDTH] <= w_q_fix;
          r_data_out[REM_LSB  +: WIDTH] <= w_r_fix;
          r_dbz                         <= r_b_zero;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign div_by_zero = r_dbz;
  assign dataOut     = r_data_out;

endmodule

// File: tb/tb_divider_seq_param.sv
// Directed bench for divider_seq_param: 32-bit and 8-bit instances, latency,
// sign rules, divide-by-zero, overflow, busy-ignore and mid-operation reset.
module tb_divider_seq_param;

  logic        clk = 1'b0;
  logic        reset;

  logic        start32, sgn32;
  logic [31:0] a32, b32;
  logic        busy32, done32, dbz32;
  logic [63:0] out32;

  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [15:0] out8;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  divider_seq_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
    .dataA(a32), .dataB(b32), .busy(busy32), .done(done32),
    .div_by_zero(dbz32), .dataOut(out32)
  );

  divider_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
    .dataA(a8), .dataB(b8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .dataOut(out8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Issue one 32-bit op; lat is the index k of the edge at which done is seen (sampled just before edge k).
  task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input int poke_k, output int lat, output logic busy_ok);
    @(negedge clk);
    start32 = 1'b1; sgn32 = sgn; a32 = a; b32 = b;
    @(posedge clk);
    lat = -1; busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start32 = (k == poke_k);
      if (k == poke_k) begin sgn32 = ~sgn; a32 = 32'd1; b32 = 32'd1; end
      if (!busy32) busy_ok = 1'b0;
      if (done32) begin lat = k; break; end
    end
    start32 = 1'b0;
  endtask

  task automatic do32(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_q, input logic [31:0] exp_r, input logic exp_dbz);
    int lat; logic bok;
    run32(sgn, a, b, 0, lat, bok);
    check({tag, " latency"}, 64'(lat), 64'd34);
    check({tag, " busy"}, 64'(bok), 64'd1);
    check({tag, " dataOut"}, out32, {exp_r, exp_q});
    check({tag, " dbz"}, 64'(dbz32), 64'(exp_dbz));
    @(negedge clk);
    check({tag, " idle"}, {62'd0, busy32, done32}, 64'd0);
  endtask

  task automatic do8(input string tag, input logic sgn, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp_out, input logic exp_dbz);
    int lat;
    lat = -1;
    @(negedge clk);
    start8 = 1'b1; sgn8 = sgn; a8 = a; b8 = b;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) begin lat = k; break; end
    end
    check({tag, " latency"}, 64'(lat), 64'd10);
    check({tag, " dataOut"}, 64'(out8), 64'(exp_out));
    check({tag, " dbz"}, 64'(dbz8), 64'(exp_dbz));
  endtask

  // Reference: {remainder, quotient} with the zero-divisor and MIN/-1 rules.
  function automatic logic [15:0] ref8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, qi, ri;
    logic [7:0] q, r;
    if (b == 8'd0) begin
      q = 8'hFF; r = a;
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else begin
      sa = int'($signed(a)); sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin
        q = 8'h80; r = 8'h00;
      end else begin
        qi = sa / sb; ri = sa % sb;
        q = qi[7:0]; r = ri[7:0];
      end
    end
    return {r, q};
  endfunction

  initial begin
    int lat;
    logic bok;
    logic [63:0] held;
    logic seen_done;
    logic [7:0] ra, rb;
    logic rs;

    reset = 1'b1;
    start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    check("reset state 32", {busy32, done32, dbz32, out32[60:0]}, 64'd0);
    check("reset out hi 32", 64'(out32[63:61]), 64'd0);
    check("reset state 8", {45'd0, busy8, done8, dbz8, out8}, 64'd0);
    reset = 1'b0;

    // Unsigned, signed sign rules, divide by zero, overflow.
    do32("u 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    held = out32;
    repeat (3) @(negedge clk);
    check("hold in idle", out32, held);
    do32("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do32("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    do32("s -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
    do32("u 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    do32("s 5/0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    do32("s -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
    do32("u 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    do32("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    do32("u min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

    // start while busy is ignored.
    run32(1'b0, 32'd100, 32'd7, 5, lat, bok);
    check("poke latency", 64'(lat), 64'd34);
    check("poke dataOut", out32, {32'd2, 32'd14});
    @(negedge clk);
    check("poke no restart", 64'(busy32), 64'd0);

    // Reset just before edge 10 aborts the operation.
    @(negedge clk);
    start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd50; b32 = 32'd3;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start32 = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("abort busy/done", {62'd0, busy32, done32}, 64'd0);
    check("abort dataOut", out32, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done32 || busy32) seen_done = 1'b1;
    end
    check("no done after abort", 64'(seen_done), 64'd0);
    do32("after abort 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // 8-bit instance: directed then random sweep.
    do8("w8 255/16", 1'b0, 8'd255, 8'd16, {8'd15, 8'd15}, 1'b0);
    do8("w8 s -128/-1", 1'b1, 8'h80, 8'hFF, {8'h00, 8'h80}, 1'b0);
    do8("w8 s -100/7", 1'b1, 8'h9C, 8'd7, {8'hFE, 8'hF2}, 1'b0);
    do8("w8 s -3/0", 1'b1, 8'hFD, 8'd0, {8'hFD, 8'hFF}, 1'b1);
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 6 == 5) ? 8'd0 : 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      do8("w8 rand", rs, ra, rb, ref8(rs, ra, rb), rb == 8'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
